fp_exp_align: RTL



---
 rtl/fp_exp_align_if.sv | 55 +++++
 rtl/fp_exp_align.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fp_exp_align_if.sv
// Handshake and operand bundle for the fp_exp_align operand-alignment stage.
// master drives operands and out_ready; slave is the alignment block itself.
interface fp_exp_align_if #(
    parameter int MANT_WIDTH = 24,
    parameter int EXP_WIDTH  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [EXP_WIDTH-1:0]  exp_a;
    logic [EXP_WIDTH-1:0]  exp_b;
    logic [EXP_WIDTH-1:0]  diff;
    logic                  borrow;
    logic [MANT_WIDTH-1:0] mant_a;
    logic [MANT_WIDTH-1:0] mant_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [MANT_WIDTH-1:0] big_mant;
    logic [MANT_WIDTH+2:0] small_mant;
    logic [EXP_WIDTH-1:0]  exp_out;
    logic                  swap;

    modport master (
        output in_valid,
        output exp_a,
        output exp_b,
        output diff,
        output borrow,
        output mant_a,
        output mant_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  big_mant,
        input  small_mant,
        input  exp_out,
        input  swap
    );

    modport slave (
        input  in_valid,
        input  exp_a,
        input  exp_b,
        input  diff,
        input  borrow,
        input  mant_a,
        input  mant_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output big_mant,
        output small_mant,
        output exp_out,
        output swap
    );
endinterface

// File: rtl/fp_exp_align.sv
// Iterative significand alignment with guard/round/sticky collection.
// Define FP_ALIGN_FAST_EN to shift up to four positions per cycle.
module fp_exp_align #(
    parameter int MANT_WIDTH = 24,
    parameter int EXP_WIDTH  = 8
) (
    input logic           clk,
    input logic           rst,
    fp_exp_align_if.slave bus
);
    localparam int SW = MANT_WIDTH + 3;
    localparam int CW = $clog2(SW);
    localparam logic [EXP_WIDTH-1:0] N_MAX = EXP_WIDTH'(MANT_WIDTH + 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         work_q, work_d;
    logic [MANT_WIDTH-1:0] big_q, big_d;
    logic [EXP_WIDTH-1:0]  exp_q, exp_d;
    logic                  swap_q, swap_d;

    logic [MANT_WIDTH-1:0] big_mant_q, big_mant_d;
    logic [SW-1:0]         small_mant_q, small_mant_d;
    logic [EXP_WIDTH-1:0]  exp_out_q, exp_out_d;
    logic                  swap_out_q, swap_out_d;
    logic                  out_valid_q, out_valid_d;

    logic                  accept;
    logic [EXP_WIDTH-1:0]  n_raw;
    logic [EXP_WIDTH-1:0]  n_clamp;
    logic [CW-1:0]         n_load;
    logic [CW-1:0]         step;
    logic [SW-1:0]         drop_mask;
    logic [SW-1:0]         shifted;
    logic                  sticky;

    assign bus.in_ready   = (state_q == S_IDLE) & ~rst;
    assign accept         = bus.in_valid & bus.in_ready;

    assign bus.out_valid  = out_valid_q;
    assign bus.big_mant   = big_mant_q;
    assign bus.small_mant = small_mant_q;
    assign bus.exp_out    = exp_out_q;
    assign bus.swap       = swap_out_q;

    // A borrow means exp_b is larger, so the distance is the negated diff.
    always_comb begin
        n_raw   = bus.borrow ? (~bus.diff + EXP_WIDTH'(1)) : bus.diff;
        n_clamp = (n_raw > N_MAX) ? N_MAX : n_raw;
        n_load  = CW'(n_clamp);
    end

    always_comb begin
`ifdef FP_ALIGN_FAST_EN
        step = (cnt_q > CW'(4)) ? CW'(4) : cnt_q;
`else
        step = CW'(1);
`endif
        // Bits 0..step all land in (or pass through) the sticky position.
        drop_mask = (SW'(2) << step) - SW'(1);
        sticky    = |(work_q & drop_mask);
        shifted   = (work_q >> step) | {{(SW-1){1'b0}}, sticky};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        big_d   = big_q;
        exp_d   = exp_q;
        swap_d  = swap_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    swap_d  = bus.borrow;
                    big_d   = bus.borrow ? bus.mant_b : bus.mant_a;
                    exp_d   = bus.borrow ? bus.exp_b : bus.exp_a;
                    work_d  = bus.borrow ? {bus.mant_a, 3'b000}
                                         : {bus.mant_b, 3'b000};
                    cnt_d   = n_load;
                    state_d = (n_load == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - step;
                if (cnt_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output registers only change when a result is committed.
    always_comb begin
        big_mant_d   = big_mant_q;
        small_mant_d = small_mant_q;
        exp_out_d    = exp_out_q;
        swap_out_d   = swap_out_q;
        out_valid_d  = (state_d == S_DONE);
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            big_mant_d   = big_d;
            small_mant_d = work_d;
            exp_out_d    = exp_d;
            swap_out_d   = swap_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            work_q       <= '0;
            big_q        <= '0;
            exp_q        <= '0;
            swap_q       <= 1'b0;
            big_mant_q   <= '0;
            small_mant_q <= '0;
            exp_out_q    <= '0;
            swap_out_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            work_q       <= work_d;
            big_q        <= big_d;
            exp_q        <= exp_d;
            swap_q       <= swap_d;
            big_mant_q   <= big_mant_d;
            small_mant_q <= small_mant_d;
            exp_out_q    <= exp_out_d;
            swap_out_q   <= swap_out_d;
            out_valid_q  <= out_valid_d;
        end
    end
endmodule
